// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory responder.
// Holds the transaction FSM encoding and the address error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Misaligned word access, or any address bit set above the storage range
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned aw);
    addr_error = (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory responder: one synchronous read-first
// read/write port with a per-byte write mask. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Reads return the word as it was before a same-edge write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the CPU memory stage.
// Optional per-byte write enables via `define DMEM_BYTE_MASK_EN (adds port be_i).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  dmem_state_e   state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          accept;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic          err_q;
  logic [3:0]    wmask;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  assign accept = (state == IDLE) && req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // WAIT lasts LATENCY-1 cycles so ack lands LATENCY cycles after accept
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (req_i) begin
          next_cnt   = '0;
          next_state = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          next_cnt   = '0;
          next_state = RESP;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= addr_i[AW+1:2];
      wdata_q <= wdata_i;
      we_q    <= we_i;
      err_q   <= addr_error(addr_i, AW);
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  logic [3:0] be_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       be_q <= 4'h0;
    else if (accept) be_q <= be_i;
  end

  assign wmask = be_q;
`else
  assign wmask = 4'hF;
`endif

  // With LATENCY=1 the read is launched on the accept edge, so index from addr_i in IDLE
  assign mem_addr = (state == IDLE) ? addr_i[AW+1:2] : idx_q;
  assign mem_we   = (state == RESP) && we_q && !err_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk_i),
    .we   (mem_we),
    .wmask(wmask),
    .addr (mem_addr),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign ack_o   = (state == RESP);
  assign busy_o  = (state != IDLE);
  assign err_o   = ack_o && err_q;
  assign rdata_o = (ack_o && !err_q) ? mem_rdata : 32'h0;

endmodule
